// File: rtl/occ_rom_arbiter_pkg.sv
// Shared types and default sizes for the rom_Occ read-port arbiter.
package occ_rom_arbiter_pkg;

    localparam int OCC_NUM_REQ = 2;
    localparam int OCC_AW      = 8;
    localparam int OCC_DW      = 32;
    localparam int OCC_ROM_LAT = 1;

    // Arbiter transaction states (2-bit encoding).
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/occ_rom_arbiter_if.sv
// Requester-side and rom_Occ-side signals of the Occ read-port arbiter.
interface occ_rom_arbiter_if
    import occ_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = OCC_NUM_REQ,
    parameter int AW      = OCC_AW,
    parameter int DW      = OCC_DW
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rvalid;
    logic [DW-1:0]         rdata;
    logic                  busy;
    logic                  ce_rom_Occ;
    logic [AW-1:0]         addr_rom_Occ;
    logic [DW-1:0]         rom_data;

    // Environment side: requesting stages plus the ROM data return.
    modport master (
        output req, req_addr, rom_data,
        input  gnt, rvalid, rdata, busy, ce_rom_Occ, addr_rom_Occ
    );

    // Arbiter side.
    modport slave (
        input  req, req_addr, rom_data,
        output gnt, rvalid, rdata, busy, ce_rom_Occ, addr_rom_Occ
    );
endinterface

// File: rtl/occ_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_idx, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 2,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_idx,
    output logic [IW-1:0]      winner,
    output logic               any
);
    logic [IW-1:0] cand;

    // Scan last_idx+1 .. last_idx+NUM_REQ; the previous owner is considered last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_idx) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
    end
endmodule

// File: rtl/occ_rom_arbiter.sv
// Shares the single rom_Occ read port between NUM_REQ fetch stages, one read in flight.
module occ_rom_arbiter
    import occ_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = OCC_NUM_REQ,
    parameter int AW      = OCC_AW,
    parameter int DW      = OCC_DW,
    parameter int ROM_LAT = OCC_ROM_LAT
) (
    input logic              clk,
    input logic              rst_n,
    occ_rom_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ROM_LAT + 1);

    arb_state_e         state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [IW-1:0]      last_idx, last_n;
    logic [IW-1:0]      win;
    logic               any;
    logic [CW-1:0]      cnt, cnt_n;
    logic [AW-1:0]      addr_q, addr_n;
    logic [DW-1:0]      rdata_q, rdata_n;
    logic [NUM_REQ-1:0] gnt_q, gnt_n;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_n;
    logic               ce_q, ce_n;
    logic               busy_q, busy_n;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req      (bus.req),
        .last_idx (last_idx),
        .winner   (win),
        .any      (any)
    );

    // State and all output registers; every output is a flop (Moore).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            idx      <= '0;
            last_idx <= IW'(NUM_REQ - 1);
            cnt      <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            ce_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            last_idx <= last_n;
            cnt      <= cnt_n;
            addr_q   <= addr_n;
            rdata_q  <= rdata_n;
            gnt_q    <= gnt_n;
            rvalid_q <= rvalid_n;
            ce_q     <= ce_n;
            busy_q   <= busy_n;
        end
    end

    // Next state and next register values; outputs are set for the state being entered.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        last_n   = last_idx;
        cnt_n    = cnt;
        addr_n   = addr_q;
        rdata_n  = rdata_q;
        gnt_n    = gnt_q;
        rvalid_n = '0;
        ce_n     = 1'b0;
        busy_n   = busy_q;
        case (state)
            ARB_IDLE: begin
                if (any) begin
                    state_n = ARB_ISSUE;
                    idx_n   = win;
                    addr_n  = bus.req_addr[win*AW +: AW];
                    gnt_n   = NUM_REQ'(1) << win;
                    ce_n    = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            ARB_ISSUE: begin
                state_n = ARB_WAIT;
                cnt_n   = CW'(ROM_LAT);
            end
            ARB_WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n  = ARB_RESP;
                    rdata_n  = bus.rom_data;
                    rvalid_n = NUM_REQ'(1) << idx;
                end
            end
            ARB_RESP: begin
                state_n = ARB_IDLE;
                last_n  = idx;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    assign bus.gnt          = gnt_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = busy_q;
    assign bus.ce_rom_Occ   = ce_q;
    assign bus.addr_rom_Occ = addr_q;
endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Self-checking bench: ROM_LAT=1 and ROM_LAT=3 arbiters, ROM models, scoreboards.
module tb_occ_rom_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    occ_rom_arbiter_if #(.NUM_REQ(2), .AW(8), .DW(32)) bus1 ();
    occ_rom_arbiter_if #(.NUM_REQ(2), .AW(8), .DW(32)) bus3 ();

    occ_rom_arbiter #(.NUM_REQ(2), .AW(8), .DW(32), .ROM_LAT(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );
    occ_rom_arbiter #(.NUM_REQ(2), .AW(8), .DW(32), .ROM_LAT(3)) dut3 (
        .clk (clk), .rst_n (rst_n), .bus (bus3)
    );

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        if (a == 8'h2A) return 32'h04030201;
        return {~a, a ^ 8'h55, a + 8'd1, a};
    endfunction

    // ROM models: data is valid only in the cycle ROM_LAT after ce is sampled.
    logic       rv1;
    logic [7:0] ra1;
    logic [2:0] v3;
    logic [7:0] a3 [3];
    always @(posedge clk) begin
        rv1   <= bus1.ce_rom_Occ;
        ra1   <= bus1.addr_rom_Occ;
        v3    <= {v3[1:0], bus3.ce_rom_Occ};
        a3[0] <= bus3.addr_rom_Occ;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign bus1.rom_data = rv1   ? rom_word(ra1)   : 32'hDEADBEEF;
    assign bus3.rom_data = v3[2] ? rom_word(a3[2]) : 32'hDEADBEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int idx; logic [7:0]  addr; } ce_t;
    typedef struct { int idx; logic [31:0] data; } rv_t;
    ce_t ce_q[$];
    rv_t rv_q[$];
    rv_t rv3_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle, then compare any ce/rvalid the DUTs show against the scoreboards.
    task automatic tick();
        ce_t c;
        rv_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (bus1.ce_rom_Occ) begin
            chk("ce_expected", 64'(ce_q.size() != 0), 64'd1);
            if (ce_q.size() != 0) begin
                c = ce_q.pop_front();
                chk("ce_addr", 64'(bus1.addr_rom_Occ), 64'(c.addr));
                chk("ce_gnt", 64'(bus1.gnt), 64'(2'(1) << c.idx));
            end
        end
        if (bus1.rvalid != 2'b00) begin
            chk("rv_expected", 64'(rv_q.size() != 0), 64'd1);
            if (rv_q.size() != 0) begin
                r = rv_q.pop_front();
                chk("rv_onehot", 64'(bus1.rvalid), 64'(2'(1) << r.idx));
                chk("rv_rdata", 64'(bus1.rdata), 64'(r.data));
            end
        end
        if (bus3.rvalid != 2'b00) begin
            chk("rv3_expected", 64'(rv3_q.size() != 0), 64'd1);
            if (rv3_q.size() != 0) begin
                r = rv3_q.pop_front();
                chk("rv3_onehot", 64'(bus3.rvalid), 64'(2'(1) << r.idx));
                chk("rv3_rdata", 64'(bus3.rdata), 64'(r.data));
            end
        end
    endtask

    // One complete transaction from IDLE with fixed cycle-by-cycle expectations.
    task automatic do_read(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] a1,
                           input int exp_idx);
        logic [7:0] ea;
        ce_t c;
        rv_t v;
        ea = (exp_idx == 1) ? a1 : a0;
        bus1.req      = r;
        bus1.req_addr = {a1, a0};
        c.idx = exp_idx; c.addr = ea;          ce_q.push_back(c);
        v.idx = exp_idx; v.data = rom_word(ea); rv_q.push_back(v);
        tick();
        chk("c1_ce", 64'(bus1.ce_rom_Occ), 64'd1);
        chk("c1_busy", 64'(bus1.busy), 64'd1);
        tick();
        chk("c2_ce", 64'(bus1.ce_rom_Occ), 64'd0);
        chk("c2_gnt", 64'(bus1.gnt), 64'(2'(1) << exp_idx));
        tick();
        chk("c3_rvalid", 64'(bus1.rvalid), 64'(2'(1) << exp_idx));
        bus1.req = 2'b00;
        tick();
        chk("c4_busy", 64'(bus1.busy), 64'd0);
        chk("c4_gnt", 64'(bus1.gnt), 64'd0);
        chk("c4_rvalid", 64'(bus1.rvalid), 64'd0);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [7:0] a0;
        logic [7:0] a1;
        int         exp_idx;
    } vec_t;

    vec_t vecs [7];
    int   last_ce;

    initial begin
        ce_t c;
        rv_t v;
        checks = 0;
        errors = 0;
        cyc    = 0;

        // Priority starts at stage 0 after reset; then round-robin over the pointer.
        vecs[0] = '{2'b01, 8'h2A, 8'h00, 0};
        vecs[1] = '{2'b01, 8'h05, 8'h06, 0};
        vecs[2] = '{2'b11, 8'h07, 8'h08, 1};
        vecs[3] = '{2'b11, 8'h09, 8'h0A, 0};
        vecs[4] = '{2'b10, 8'h0B, 8'h0C, 1};
        vecs[5] = '{2'b11, 8'h0D, 8'h0E, 0};
        vecs[6] = '{2'b10, 8'h0F, 8'hF0, 1};

        rst_n         = 1'b0;
        bus1.req      = '0;
        bus1.req_addr = '0;
        bus3.req      = '0;
        bus3.req_addr = '0;
        tick();
        tick();
        chk("rst_gnt", 64'(bus1.gnt), 64'd0);
        chk("rst_rvalid", 64'(bus1.rvalid), 64'd0);
        chk("rst_ce", 64'(bus1.ce_rom_Occ), 64'd0);
        chk("rst_addr", 64'(bus1.addr_rom_Occ), 64'd0);
        chk("rst_rdata", 64'(bus1.rdata), 64'd0);
        chk("rst_busy", 64'(bus1.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++)
            do_read(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].exp_idx);

        // Contention: both held, grants alternate 0,1,0,1 with ce every 4 cycles.
        bus1.req_addr = {8'h20, 8'h10};
        bus1.req      = 2'b11;
        for (int i = 0; i < 4; i++) begin
            c.idx = i % 2; c.addr = (i % 2) ? 8'h20 : 8'h10; ce_q.push_back(c);
            v.idx = i % 2; v.data = rom_word(c.addr);        rv_q.push_back(v);
        end
        last_ce = -1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (bus1.ce_rom_Occ) begin
                if (last_ce >= 0) chk("ce_spacing", 64'(cyc - last_ce), 64'd4);
                last_ce = cyc;
            end
        end
        bus1.req = 2'b00;
        tick();
        chk("cont_idle", 64'(bus1.busy), 64'd0);
        chk("cont_all_ce", 64'(ce_q.size()), 64'd0);

        // Requester drops during WAIT: transaction still completes once, then idle.
        bus1.req_addr = {8'h33, 8'h44};
        bus1.req      = 2'b10;
        c.idx = 1; c.addr = 8'h33;          ce_q.push_back(c);
        v.idx = 1; v.data = rom_word(8'h33); rv_q.push_back(v);
        tick();
        tick();
        bus1.req = 2'b00;
        tick();
        chk("drop_rvalid", 64'(bus1.rvalid), 64'd2);
        tick();
        tick();
        chk("drop_idle", 64'(bus1.busy), 64'd0);

        // Make stage 0 the last served, then reset mid-WAIT of a stage-1 read.
        do_read(2'b01, 8'h55, 8'h66, 0);
        bus1.req_addr = {8'h77, 8'h44};
        bus1.req      = 2'b11;
        c.idx = 1; c.addr = 8'h77; ce_q.push_back(c);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_gnt", 64'(bus1.gnt), 64'd0);
        chk("mrst_ce", 64'(bus1.ce_rom_Occ), 64'd0);
        chk("mrst_addr", 64'(bus1.addr_rom_Occ), 64'd0);
        chk("mrst_rdata", 64'(bus1.rdata), 64'd0);
        chk("mrst_busy", 64'(bus1.busy), 64'd0);
        tick();
        rst_n    = 1'b1;
        bus1.req = 2'b00;
        tick();
        tick();
        chk("mrst_no_rvalid", 64'(bus1.rvalid), 64'd0);
        // Pointer was reset, so stage 0 wins over stage 1.
        do_read(2'b11, 8'h44, 8'h77, 0);

        // ROM_LAT=3: ce at cycle 1 only, rvalid at cycle 5 with data from cycle 4.
        bus3.req_addr = {8'h00, 8'h2A};
        bus3.req      = 2'b01;
        v.idx = 0; v.data = 32'h04030201; rv3_q.push_back(v);
        tick();
        chk("l3_ce", 64'(bus3.ce_rom_Occ), 64'd1);
        chk("l3_addr", 64'(bus3.addr_rom_Occ), 64'h2A);
        for (int t = 2; t <= 4; t++) begin
            tick();
            chk("l3_wait_ce", 64'(bus3.ce_rom_Occ), 64'd0);
            chk("l3_wait_rvalid", 64'(bus3.rvalid), 64'd0);
            chk("l3_wait_busy", 64'(bus3.busy), 64'd1);
        end
        tick();
        chk("l3_rvalid", 64'(bus3.rvalid), 64'd1);
        bus3.req = 2'b00;
        tick();
        chk("l3_idle", 64'(bus3.busy), 64'd0);

        tick();
        chk("sb_ce_empty", 64'(ce_q.size()), 64'd0);
        chk("sb_rv_empty", 64'(rv_q.size()), 64'd0);
        chk("sb_rv3_empty", 64'(rv3_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
